uart_fifo_bridge: RTL and testbench
===================================

UART_FIFO_BRIDGE -- requirements
Module: uart_fifo_bridge

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries; power of two, 2..256.
REQ-002 SHALL have parameter WIDTH, default 8, bits per UART byte.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port rx_valid  input  1  one-cycle strobe from the receiver marking a new byte.
REQ-006 SHALL have port rx_data  input  WIDTH  receiver byte, valid when rx_valid=1.
REQ-007 SHALL have port tx_busy  input  1  transmitter busy, high while a frame is being shifted out.
REQ-008 SHALL have port tx_send  output  1  one-cycle start strobe to the transmitter.
REQ-009 SHALL have port tx_data  output  WIDTH  byte to transmit, held stable from tx_send until tx_busy falls.
REQ-010 SHALL have port count  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-011 SHALL have ports full and empty  output  1 each  FIFO status, combinational from count.

Function
REQ-012 SHALL write rx_data into FIFO on the cycle rx_valid=1 when not full, or when full and a pop occurs in the same cycle.
REQ-013 SHALL drop the byte when rx_valid=1, full=1, and no same-cycle pop; FIFO contents unchanged.
REQ-014 SHALL wrap read and write pointers modulo DEPTH; count = writes minus pops, never exceeding DEPTH.
REQ-015 SHALL run the TX FSM with states IDLE, LOAD, SEND, WAIT_BUSY, WAIT_DONE.
REQ-016 IDLE: if empty=0 and tx_busy=0, pop head entry -> LOAD; else stay.
REQ-017 LOAD: register popped byte into tx_data -> SEND.
REQ-018 SEND: drive tx_send=1 for exactly this cycle -> WAIT_BUSY.
REQ-019 WAIT_BUSY: stay until tx_busy=1 -> WAIT_DONE.
REQ-020 WAIT_DONE: stay until tx_busy=0 -> IDLE.
REQ-021 SHALL have a 3-cycle minimum latency from rx_valid into an empty FIFO with FSM idle to tx_send (write cycle, IDLE pop, LOAD; tx_send in the following cycle).
REQ-022 SHALL allow simultaneous write and pop; count unchanged, both take effect.
REQ-023 SHALL never issue tx_send while tx_busy=1 or while in WAIT_BUSY or WAIT_DONE.

Reset
REQ-024 On rst=1 at a clock edge: FSM->IDLE, pointers=0, count=0, empty=1, full=0, tx_send=0, tx_data=0.
REQ-025 Reset mid-transfer SHALL discard all queued bytes and the in-flight byte; no tx_send pulse after reset until a new write arrives.
REQ-026 rx_valid asserted while rst=1 SHALL be ignored.

Configuration
REQ-027 Macro UART_FIFO_OVF_EN SHALL, when defined, add output ovf (1 bit): sticky high from the cycle after a REQ-013 drop until rst; reset value 0.
REQ-028 Without UART_FIFO_OVF_EN, port ovf SHALL not exist and all other behaviour SHALL be identical.

Structure
REQ-029 Package uart_pkg SHALL hold the byte_t typedef (logic [7:0]), the tx_state_t enum (REQ-015), and the default DEPTH constant.
REQ-030 Storage SHALL be a sub-module sync_fifo (push, pop, din, dout, count, full, empty); the TX FSM SHALL reside in uart_fifo_bridge.

Verification
REQ-031 Single byte: rx_valid with 0x41, tx_busy model rises 1 cycle after tx_send and stays high 10 cycles -> tx_send exactly 3 cycles after write, tx_data=0x41, count returns to 0.
REQ-032 Burst: 5 back-to-back bytes 0x10..0x14 with busy model -> transmitted in order 0x10..0x14, one tx_send per byte, none during busy.
REQ-033 Overflow: tx_busy held high, 17 writes 0x00..0x10 with DEPTH=16 -> full=1, byte 0x10 dropped, ovf=1 (macro on); after release, 0x00..0x0F sent.
REQ-034 Simultaneous: FIFO full, FSM in IDLE popping, rx_valid with 0xAA same cycle -> 0xAA accepted, count stays 16, no ovf.
REQ-035 Reset mid-operation: 3 bytes queued, rst pulsed in WAIT_DONE -> count=0, empty=1, no further tx_send; next write 0x55 transmitted normally.
REQ-036 Wrap: 40 bytes at a paced rate through DEPTH=16 -> all 40 received in order, pointers wrapped twice, no drops.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART FIFO bridge.
//   byte_t      : one UART byte
//   tx_state_t  : transmit-side sequencer states
//   DEFAULT_*   : default FIFO depth and byte width
package uart_pkg;

    localparam int DEFAULT_DEPTH = 16;
    localparam int DEFAULT_WIDTH = 8;

    typedef logic [7:0] byte_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        WAIT_BUSY,
        WAIT_DONE
    } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through read port.
//   clk, rst        : clock and synchronous active-high reset
//   push, din       : write request and data; accepted when not full, or when
//                     full and a pop happens in the same cycle
//   pop, dout       : read request; dout always shows the head entry
//   count           : occupancy, 0..DEPTH
//   full, empty     : status decoded from count
module sync_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    assign do_pop  = pop && !empty;
    // When full, the slot being freed by a same-cycle pop is the one written.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_fifo_bridge.sv
// Buffers bytes from a UART receiver and feeds them one at a time to a UART
// transmitter, handshaking on the transmitter's busy flag.
//   clk, rst          : clock and synchronous active-high reset
//   rx_valid, rx_data : one-cycle receive strobe and byte
//   tx_busy           : transmitter busy while shifting a frame
//   tx_send, tx_data  : one-cycle start strobe and the byte to send; tx_data
//                       holds until the next byte is loaded
//   count, full, empty: FIFO occupancy and status
//   ovf               : sticky overflow flag, present only when the macro
//                       UART_FIFO_OVF_EN is defined
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for data and an idle transmitter; pops head entry
// LOAD      | popped byte copied into tx_data
// SEND      | tx_send pulsed for this single cycle
// WAIT_BUSY | waiting for the transmitter to acknowledge with tx_busy=1
// WAIT_DONE | waiting for tx_busy to fall at end of frame
module uart_fifo_bridge
    import uart_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rx_valid,
    input  logic [WIDTH-1:0]         rx_data,
    input  logic                     tx_busy,
    output logic                     tx_send,
    output logic [WIDTH-1:0]         tx_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
`ifdef UART_FIFO_OVF_EN
    ,
    output logic                     ovf
`endif
);

    tx_state_t        state;
    tx_state_t        state_nxt;
    logic             pop;
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] pop_byte;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_valid),
        .pop   (pop),
        .din   (rx_data),
        .dout  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        tx_send   = 1'b0;
        case (state)
            IDLE: begin
                if (!empty && !tx_busy) begin
                    pop       = 1'b1;
                    state_nxt = LOAD;
                end
            end
            // Holding in LOAD if busy appears keeps tx_send off a busy line.
            LOAD: begin
                if (!tx_busy) begin
                    state_nxt = SEND;
                end
            end
            SEND: begin
                tx_send   = 1'b1;
                state_nxt = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_nxt = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The head is captured at pop time: a same-cycle write into a full FIFO
    // lands in the slot just vacated, so it cannot be re-read in LOAD.
    always_ff @(posedge clk) begin
        if (rst) begin
            pop_byte <= '0;
            tx_data  <= '0;
        end else begin
            if (pop) begin
                pop_byte <= head;
            end
            if (state == LOAD) begin
                tx_data <= pop_byte;
            end
        end
    end

`ifdef UART_FIFO_OVF_EN
    logic drop;

    assign drop = rx_valid && full && !pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Directed testbench for uart_fifo_bridge (DEPTH=16, WIDTH=8). Inputs change
// on the falling edge; outputs are sampled on the falling edge. A transmitter
// model raises tx_busy one cycle after tx_send for 10 cycles; hold_busy can
// force it high. Every tx_send is logged for in-order checking.
module tb_uart_fifo_bridge;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       tx_busy;
    logic       tx_send;
    logic [7:0] tx_data;
    logic [4:0] count;
    logic       full;
    logic       empty;
`ifdef UART_FIFO_OVF_EN
    logic       ovf;
`endif

    int tests = 0;
    int fails = 0;

    logic  hold_busy  = 1'b0;
    logic  model_busy = 1'b0;
    logic  send_seen  = 1'b0;
    int    busy_left  = 0;
    byte_t tx_log[$];

    assign tx_busy = hold_busy | model_busy;

    uart_fifo_bridge #(
        .DEPTH (16),
        .WIDTH (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .tx_busy  (tx_busy),
        .tx_send  (tx_send),
        .tx_data  (tx_data),
        .count    (count),
        .full     (full),
        .empty    (empty)
`ifdef UART_FIFO_OVF_EN
        ,
        .ovf      (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Transmitter model and send monitor.
    always @(negedge clk) begin
        if (busy_left != 0) begin
            busy_left--;
            if (busy_left == 0) model_busy = 1'b0;
        end
        if (send_seen) begin
            model_busy = 1'b1;
            busy_left  = 10;
            send_seen  = 1'b0;
        end
        if (tx_send === 1'b1) begin
            check("send_while_busy", {31'd0, tx_busy}, 32'd0);
            tx_log.push_back(tx_data);
            send_seen = 1'b1;
        end
    end

    task automatic wait_idle(input string tag);
        int run = 0;
        int n   = 0;
        while (run < 4 && n < 2000) begin
            @(negedge clk);
            n++;
            if (empty && !tx_busy && !send_seen && !tx_send) run++;
            else run = 0;
        end
        check({tag, "_idle_timeout"}, {31'd0, run >= 4}, 32'd1);
    endtask

    task automatic write_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        rx_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_count",   {27'd0, count},   32'd0);
        check("rst_empty",   {31'd0, empty},   32'd1);
        check("rst_full",    {31'd0, full},    32'd0);
        check("rst_tx_send", {31'd0, tx_send}, 32'd0);
        check("rst_tx_data", {24'd0, tx_data}, 32'd0);
`ifdef UART_FIFO_OVF_EN
        check("rst_ovf",     {31'd0, ovf},     32'd0);
`endif

        // Single byte: tx_send three cycles after the write cycle
        write_byte(8'h41);
        check("single_count_after_write", {27'd0, count}, 32'd1);
        check("single_send_c1", {31'd0, tx_send}, 32'd0);
        @(negedge clk);
        check("single_send_c2", {31'd0, tx_send}, 32'd0);
        check("single_count_after_pop", {27'd0, count}, 32'd0);
        @(negedge clk);
        check("single_send_c3", {31'd0, tx_send}, 32'd1);
        check("single_tx_data", {24'd0, tx_data}, 32'h41);
        @(negedge clk);
        check("single_send_pulse_width", {31'd0, tx_send}, 32'd0);
        wait_idle("single");
        check("single_log_size", tx_log.size(), 32'd1);
        check("single_log0", {24'd0, tx_log[0]}, 32'h41);
        check("single_count_end", {27'd0, count}, 32'd0);

        // Burst of five back-to-back bytes
        tx_log.delete();
        for (int i = 0; i < 5; i++) write_byte(8'h10 + 8'(i));
        wait_idle("burst");
        check("burst_log_size", tx_log.size(), 32'd5);
        for (int i = 0; i < 5; i++)
            check($sformatf("burst_byte%0d", i), {24'd0, tx_log[i]}, 32'h10 + i);

        // Overflow: 17 writes with transmitter held busy
        tx_log.delete();
        hold_busy = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 17; i++) write_byte(8'(i));
        check("ovf_count", {27'd0, count}, 32'd16);
        check("ovf_full",  {31'd0, full},  32'd1);
        check("ovf_empty", {31'd0, empty}, 32'd0);
        check("ovf_no_send_while_held", tx_log.size(), 32'd0);
`ifdef UART_FIFO_OVF_EN
        check("ovf_flag", {31'd0, ovf}, 32'd1);
`endif
        hold_busy = 1'b0;
        wait_idle("ovf");
        check("ovf_log_size", tx_log.size(), 32'd16);
        for (int i = 0; i < 16; i++)
            check($sformatf("ovf_byte%0d", i), {24'd0, tx_log[i]}, i);

        // Simultaneous push and pop on a full FIFO
        do_reset();
        tx_log.delete();
        hold_busy = 1'b1;
        for (int i = 0; i < 16; i++) write_byte(8'h20 + 8'(i));
        check("simul_full_before", {31'd0, full}, 32'd1);
        hold_busy = 1'b0;
        write_byte(8'hAA);
        check("simul_count", {27'd0, count}, 32'd16);
        check("simul_full_after", {31'd0, full}, 32'd1);
`ifdef UART_FIFO_OVF_EN
        check("simul_no_ovf", {31'd0, ovf}, 32'd0);
`endif
        wait_idle("simul");
        check("simul_log_size", tx_log.size(), 32'd17);
        check("simul_first", {24'd0, tx_log[0]},  32'h20);
        check("simul_last_old", {24'd0, tx_log[15]}, 32'h2F);
        check("simul_aa", {24'd0, tx_log[16]}, 32'hAA);

        // Reset while the first of three bytes is in WAIT_DONE
        tx_log.delete();
        write_byte(8'h61);
        write_byte(8'h62);
        write_byte(8'h63);
        repeat (5) @(negedge clk);
        check("midrst_count_before", {27'd0, count}, 32'd2);
        check("midrst_in_flight_busy", {31'd0, tx_busy}, 32'd1);
        rst      = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'h99;
        @(negedge clk);
        rst      = 1'b0;
        rx_valid = 1'b0;
        check("midrst_count", {27'd0, count}, 32'd0);
        check("midrst_empty", {31'd0, empty}, 32'd1);
        check("midrst_tx_data", {24'd0, tx_data}, 32'd0);
        check("midrst_tx_send", {31'd0, tx_send}, 32'd0);
        tx_log.delete();
        repeat (30) @(negedge clk);
        check("midrst_no_send", tx_log.size(), 32'd0);
        check("midrst_still_empty", {31'd0, empty}, 32'd1);
        write_byte(8'h55);
        wait_idle("midrst");
        check("midrst_log_size", tx_log.size(), 32'd1);
        check("midrst_byte", {24'd0, tx_log[0]}, 32'h55);

        // Wrap: 40 paced bytes through a 16-entry FIFO
        tx_log.delete();
        for (int i = 0; i < 40; i++) begin
            write_byte(8'h80 + 8'(i));
            repeat (11) @(negedge clk);
        end
        wait_idle("wrap");
        check("wrap_log_size", tx_log.size(), 32'd40);
        for (int i = 0; i < 40; i++)
            check($sformatf("wrap_byte%0d", i), {24'd0, tx_log[i]}, 32'h80 + i);
        check("wrap_count_end", {27'd0, count}, 32'd0);
`ifdef UART_FIFO_OVF_EN
        check("wrap_no_ovf", {31'd0, ovf}, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
